// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit saturating counter, BTB entry layout
// and the counter step helpers used when training.
package bp_pkg;

    // Widest address the predictor stores; tags and targets are kept at this
    // width and zero-extended from the narrower per-instance fields.
    localparam int XLEN = 32;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'd0;
    localparam ctr_t WNT = 2'd1;
    localparam ctr_t WT  = 2'd2;
    localparam ctr_t ST  = 2'd3;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] tgt;
        ctr_t            ctr;
    } btb_entry_t;

    // Empty entry: invalid, weakly not-taken.
    localparam btb_entry_t ENTRY_CLEAR = '{valid: 1'b0, tag: '0, tgt: '0, ctr: WNT};

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == ST) ? ST : ctr_t'(c + 2'd1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/next_pc_predictor_if.sv
// Fetch-side lookup, EX-side resolution and next-PC/statistics outputs of
// the next-PC predictor, bundled for the PC-register stage.
interface next_pc_predictor_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_f;
    logic             ex_valid;
    logic             ex_is_jump;
    logic [WIDTH-1:0] ex_pc;
    logic             ex_taken;
    logic [WIDTH-1:0] ex_target;
    logic             ex_pred_taken;
    logic [WIDTH-1:0] ex_pred_target;
    logic [WIDTH-1:0] pc_next;
    logic             pred_taken_f;
    logic [WIDTH-1:0] pred_target_f;
    logic             mispredict;
    logic [31:0]      branch_cnt;
    logic [31:0]      mispred_cnt;

    modport master (
        output pc_f, ex_valid, ex_is_jump, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pc_next, pred_taken_f, pred_target_f, mispredict,
               branch_cnt, mispred_cnt
    );

    modport slave (
        input  pc_f, ex_valid, ex_is_jump, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pc_next, pred_taken_f, pred_target_f, mispredict,
               branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/next_pc_predictor_btb_table.sv
// Direct-mapped BTB held in flops: one asynchronous lookup port and one
// training port that read-modify-writes the addressed entry at the clock edge.
// Lookups always see the contents from before this cycle's training write.
module btb_table
    import bp_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int IDX         = $clog2(BTB_ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IDX-1:0]  rd_idx,
    output btb_entry_t      rd_entry,
    input  logic            upd_en,
    input  logic [IDX-1:0]  upd_idx,
    input  logic [XLEN-1:0] upd_tag,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            upd_jump
);

    btb_entry_t entries [BTB_ENTRIES];

    generate
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
            btb_entry_t entry_reg;
            btb_entry_t entry_next;
            logic       sel;
            logic       hit;

            // Training: counter step on a tag hit, allocation on a taken miss.
            always_comb begin
                entry_next = entry_reg;
                sel        = upd_en && (upd_idx == IDX'(gi));
                hit        = entry_reg.valid && (entry_reg.tag == upd_tag);
                if (sel) begin
                    if (hit) begin
                        if (upd_jump) begin
                            entry_next.ctr = ST;
                            entry_next.tgt = upd_target;
                        end else if (upd_taken) begin
                            entry_next.ctr = sat_inc(entry_reg.ctr);
                            entry_next.tgt = upd_target;
                        end else begin
                            entry_next.ctr = sat_dec(entry_reg.ctr);
                        end
                    end else if (upd_taken) begin
                        entry_next = '{valid: 1'b1, tag: upd_tag, tgt: upd_target,
                                       ctr: (upd_jump ? ST : WT)};
                    end
                end
            end

            // Entry register; reset wins over a same-cycle training write.
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= ENTRY_CLEAR;
                end else begin
                    entry_reg <= entry_next;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign rd_entry = entries[rd_idx];

endmodule

// File: rtl/next_pc_predictor.sv
// Next-PC selection for the fetch PC register: BTB prediction for pc_f,
// overridden by the EX-stage correct PC on a misprediction, plus saturating
// counts of resolved control-flow instructions and mispredictions.
module next_pc_predictor
    import bp_pkg::*;
#(
    parameter int WIDTH       = XLEN,   // must not exceed XLEN
    parameter int BTB_ENTRIES = 16
) (
    input logic               clk,
    input logic               rst,
    next_pc_predictor_if.slave bus
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    logic [IDX-1:0]   f_idx;
    logic [IDX-1:0]   e_idx;
    logic [XLEN-1:0]  e_tag;
    btb_entry_t       f_entry;
    logic             f_hit;
    logic             pred_taken;
    logic [WIDTH-1:0] f_seq;
    logic [WIDTH-1:0] pred_target;
    logic             act_taken;
    logic             mispredict;
    logic [WIDTH-1:0] correct_pc;
    logic [31:0]      branch_cnt_reg;
    logic [31:0]      mispred_cnt_reg;

    btb_table #(
        .BTB_ENTRIES (BTB_ENTRIES),
        .IDX         (IDX)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (f_idx),
        .rd_entry   (f_entry),
        .upd_en     (bus.ex_valid),
        .upd_idx    (e_idx),
        .upd_tag    (e_tag),
        .upd_target (XLEN'(bus.ex_target)),
        .upd_taken  (act_taken),
        .upd_jump   (bus.ex_is_jump)
    );

    // Fetch lookup: predict taken only on a tag hit with a taken-leaning counter.
    always_comb begin
        f_idx       = bus.pc_f[IDX+1:2];
        f_hit       = f_entry.valid && (f_entry.tag == XLEN'(bus.pc_f[WIDTH-1:IDX+2]));
        pred_taken  = f_hit && f_entry.ctr[1];
        f_seq       = bus.pc_f + WIDTH'(4);
        pred_target = pred_taken ? f_entry.tgt[WIDTH-1:0] : f_seq;
    end

    // EX resolution: compare actual outcome against what fetch predicted.
    always_comb begin
        e_idx      = bus.ex_pc[IDX+1:2];
        e_tag      = XLEN'(bus.ex_pc[WIDTH-1:IDX+2]);
        act_taken  = bus.ex_is_jump | bus.ex_taken;
        mispredict = bus.ex_valid &&
                     ((act_taken != bus.ex_pred_taken) ||
                      (act_taken && (bus.ex_target != bus.ex_pred_target)));
        correct_pc = act_taken ? bus.ex_target : bus.ex_pc + WIDTH'(4);
    end

    // Statistics counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            if (bus.ex_valid && (branch_cnt_reg != '1)) begin
                branch_cnt_reg <= branch_cnt_reg + 32'd1;
            end
            if (mispredict && (mispred_cnt_reg != '1)) begin
                mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
            end
        end
    end

    assign bus.pc_next       = mispredict ? correct_pc : pred_target;
    assign bus.pred_taken_f  = pred_taken;
    assign bus.pred_target_f = pred_target;
    assign bus.mispredict    = mispredict;
    assign bus.branch_cnt    = branch_cnt_reg;
    assign bus.mispred_cnt   = mispred_cnt_reg;

endmodule
